mod_inverse: RTL and testbench

- Sequential modular inverse over the NTT prime p = 65537 (2^16+1).
- Computes a^-1 mod p by Fermat: a^(p-2) = a^65535, using left-to-right square-and-multiply with one modular multiply per cycle.
- It is the inverse-direction companion to the combinational reducer.
- Sits beside the NTT/INTT datapath to produce n^-1 and inverse twiddle factors; valid/ready on both sides.

---
 rtl/mod_inverse.sv | 129 ++++++++++++
 tb/tb_mod_inverse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse.sv
// mod_inverse: sequential modular inverse over p = 65537 (2^16 + 1).
// Computes a^(p-2) = a^65535 mod p by left-to-right square-and-multiply,
// one modular multiply per cycle, with valid/ready handshakes on both sides.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_data/in_valid      operand (any unsigned value) and its valid
//   in_ready              block can accept an operand (high only in IDLE)
//   out_data/out_err      inverse in [0, 65536] zero-extended; err = operand == 0 mod p
//   out_valid/out_ready   result valid and consumer accept
//   busy                  high in every state except IDLE
module mod_inverse #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned RW    = 17;
  localparam int unsigned PW    = 34;
  localparam int unsigned FW    = 19;
  localparam int unsigned CW    = 4;
  localparam logic [RW-1:0] P   = RW'(65537);
  localparam logic [CW-1:0] LAST = CW'(14);

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    SQUARE,
    MULT,
    DONE
  } state_t;

  state_t           r_state;
  logic [width-1:0] r_in;
  logic [RW-1:0]    r_a;
  logic [RW-1:0]    r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [RW-1:0]    w_red;
  logic [RW-1:0]    w_mul_b;
  logic [PW-1:0]    w_prod;
  logic [FW-1:0]    w_fold;
  logic [FW-1:0]    w_fold_fix;
  logic [RW-1:0]    w_mm;

  // Full-width reduction of the captured operand by the constant modulus.
  assign w_red = RW'(r_in % width'(P));

  // Shared multiplier: r*r while squaring, r*a while multiplying.
  assign w_mul_b = (r_state == MULT) ? r_a : r_r;
  assign w_prod  = PW'(r_r) * PW'(w_mul_b);

  // Fold with 2^16 = -1 and 2^32 = 1 (mod p); the sum lies in [-65535, 65536],
  // so a single conditional add of p brings it into [0, 65536].
  assign w_fold     = FW'(w_prod[15:0]) - FW'(w_prod[31:16]) + FW'(w_prod[32]);
  assign w_fold_fix = w_fold + FW'(P);
  assign w_mm       = w_fold[FW-1] ? w_fold_fix[RW-1:0] : w_fold[RW-1:0];

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_in      <= '0;
      r_a       <= '0;
      r_r       <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_in     <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= REDUCE;
          end
        end
        REDUCE: begin
          r_a     <= w_red;
          r_r     <= w_red;
          r_cnt   <= '0;
          r_err   <= (w_red == '0);
          r_state <= SQUARE;
        end
        SQUARE: begin
          r_r     <= w_mm;
          r_state <= MULT;
        end
        MULT: begin
          // Exponent goes e -> 2e+1 per iteration; 15 iterations give 65535.
          r_r     <= w_mm;
          r_cnt   <= r_cnt + CW'(1);
          r_state <= (r_cnt == LAST) ? DONE : SQUARE;
        end
        DONE: begin
          // First DONE cycle publishes the result; it then holds until accepted.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= width'(r_r);
            out_err   <= r_err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
module tb_mod_inverse;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int n_checks;
  int n_pass;

  mod_inverse #(.width(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_err  (out_err),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

  // Reference inverse by the extended Euclidean algorithm; 0 when no inverse.
  function automatic longint inv_ref(input logic [31:0] v);
    longint a, t, nt, r, nr, q, tmp;
    a = longint'(v) % 65537;
    if (a == 0) return 0;
    t = 0; nt = 1; r = 65537; nr = a;
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + 65537;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: offer v, check latency and result, stall, then accept.
  task automatic do_op(input logic [31:0] v, input int stall, input bit junk);
    longint     exp_d;
    bit         exp_e;
    int         lat;
    bit         bad;
    logic [31:0] hd;
    logic        he;
    exp_d = inv_ref(v);
    exp_e = ((longint'(v) % 65537) == 0);
    in_data  = v;
    in_valid = 1'b1;
    lat = 0;
    while (in_ready !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    tick();
    chk("in_ready_after_accept", 64'(in_ready), 64'd0);
    in_valid = junk;
    if (junk) in_data = $urandom;
    lat = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      tick();
      lat++;
      if (junk) in_data = $urandom;
    end
    in_valid = 1'b0;
    chk("latency", 64'(lat), 64'd32);
    chk("ready_low_busy_high", 64'(bad), 64'd0);
    chk("out_data", 64'(out_data), 64'(exp_d));
    chk("out_err", 64'(out_err), 64'(exp_e));
    if (!exp_e)
      chk("a_times_inv", 64'((longint'(v) % 65537) * longint'(out_data) % 65537), 64'd1);
    chk("in_ready_in_done", 64'(in_ready), 64'd0);
    hd = out_data;
    he = out_err;
    bad = 1'b0;
    for (int k = 0; k < stall; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== hd || out_err !== he || in_ready !== 1'b0) bad = 1'b1;
    end
    if (stall > 0) chk("stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_rise", 64'(in_ready), 64'd1);
    chk("busy_clear", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_out_err"},   64'(out_err),   64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  initial begin
    int  lat;
    bit  bad;
    logic [31:0] v;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_reset_values("reset");
    rst = 1'b0;

    // Directed operands: basic, back-to-back, -1, wide, zero.
    do_op(32'd2, 0, 1'b0);
    do_op(32'd1, 0, 1'b0);
    do_op(32'd3, 0, 1'b1);
    do_op(32'd65536, 0, 1'b1);
    do_op(32'd65546, 0, 1'b0);
    do_op(32'd65537, 0, 1'b0);
    do_op(32'd0, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 0, 1'b0);

    // Backpressure for 10 cycles.
    do_op(32'd12345, 10, 1'b0);

    // Reset mid-computation: no out_valid may follow.
    in_data  = 32'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("mid_reset");
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("no_valid_after_reset", 64'(bad), 64'd0);
    do_op(32'd5, 0, 1'b0);

    // Reset while holding a result in DONE.
    in_data  = 32'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    chk("done_reached", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_values("done_reset");

    // Randomised sweep with stalls and ignored in_valid traffic while busy.
    for (int i = 0; i < 150; i++) begin
      if (i % 3 == 0) v = $urandom;
      else v = 32'($urandom_range(1, 65536));
      do_op(v, int'($urandom_range(0, 4)), (i % 2) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
